// File: rtl/conv_win_pkg.sv
// Shared types and helpers for the convolution window sequencer.
package conv_win_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a range of n values; never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_pad_fetch.sv
// Fetches one window element at a fixed (DR, DC) offset from the window centre.
// Edge handling: replicate padding by default, zeros when CONV_WIN_ZERO_PAD_EN is defined.
module conv_pad_fetch
  import conv_win_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int DR     = 0,
  parameter int DC     = 0
) (
  input  logic [IMG_H*IMG_W*DATA_W-1:0] i_frame,
  input  logic [cw(IMG_H)-1:0]          i_row,
  input  logic [cw(IMG_W)-1:0]          i_col,
  output logic [DATA_W-1:0]             o_pix
);

  localparam int RW = cw(IMG_H);
  localparam int CW = cw(IMG_W);
  localparam logic signed [8:0] OFF_R = 9'(DR);
  localparam logic signed [8:0] OFF_C = 9'(DC);
  localparam logic signed [8:0] MAX_R = 9'(IMG_H - 1);
  localparam logic signed [8:0] MAX_C = 9'(IMG_W - 1);

  logic signed [8:0] w_r;
  logic signed [8:0] w_c;
  logic [RW-1:0]     w_rc;
  logic [CW-1:0]     w_cc;
  logic [DATA_W-1:0] w_pix;

  always_comb begin
    w_r   = $signed(9'(i_row)) + OFF_R;
    w_c   = $signed(9'(i_col)) + OFF_C;
    // Clamped coordinates address the nearest edge pixel.
    w_rc  = (w_r < 0) ? '0 : (w_r > MAX_R) ? RW'(IMG_H - 1) : RW'(w_r);
    w_cc  = (w_c < 0) ? '0 : (w_c > MAX_C) ? CW'(IMG_W - 1) : CW'(w_c);
    w_pix = i_frame[(int'(w_rc) * IMG_W + int'(w_cc)) * DATA_W +: DATA_W];
  end

`ifdef CONV_WIN_ZERO_PAD_EN
  logic w_oob;
  assign w_oob = (w_r < 0) || (w_r > MAX_R) || (w_c < 0) || (w_c > MAX_C);
  assign o_pix = w_oob ? '0 : w_pix;
`else
  assign o_pix = w_pix;
`endif

endmodule

// File: rtl/conv_window_seq.sv
// Captures a frame and streams KxK windows over it, N_PASS raster scans per frame.
// Build option: CONV_WIN_ZERO_PAD_EN selects zero padding instead of edge replication.
module conv_window_seq
  import conv_win_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int K      = 3,
  parameter int N_PASS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IMG_H*IMG_W*DATA_W-1:0] in_tensor,
  input  logic                          win_ready,
  output logic                          win_valid,
  output logic [K*K*DATA_W-1:0]         win_data,
  output logic [cw(IMG_H)-1:0]          row,
  output logic [cw(IMG_W)-1:0]          col,
  output logic [cw(N_PASS)-1:0]         pass_idx,
  output logic                          win_last,
  output logic                          busy,
  output logic                          done
);

  localparam int RW = cw(IMG_H);
  localparam int CW = cw(IMG_W);
  localparam int PW = cw(N_PASS);
  localparam int P  = K / 2;

  state_t                        r_state;
  logic [IMG_H*IMG_W*DATA_W-1:0] r_frame;
  logic [RW-1:0]                 r_row;
  logic [CW-1:0]                 r_col;
  logic [PW-1:0]                 r_pass;

  logic w_col_end;
  logic w_row_end;
  logic w_pass_end;

  assign w_col_end  = (r_col == CW'(IMG_W - 1));
  assign w_row_end  = (r_row == RW'(IMG_H - 1));
  assign w_pass_end = (r_pass == PW'(N_PASS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_frame <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_pass  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_frame <= in_tensor;
            r_row   <= '0;
            r_col   <= '0;
            r_pass  <= '0;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          // Counters advance only on an accepted window.
          if (win_ready) begin
            if (w_col_end) begin
              r_col <= '0;
              if (w_row_end) begin
                r_row <= '0;
                if (w_pass_end) begin
                  r_pass  <= '0;
                  r_state <= DONE;
                end else begin
                  r_pass <= r_pass + 1'b1;
                end
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign win_valid = (r_state == SCAN);
  assign win_last  = (r_state == SCAN) && w_row_end && w_col_end;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign row       = r_row;
  assign col       = r_col;
  assign pass_idx  = r_pass;

  for (genvar gi = 0; gi < K; gi++) begin : g_win_r
    for (genvar gj = 0; gj < K; gj++) begin : g_win_c
      conv_pad_fetch #(
        .DATA_W (DATA_W),
        .IMG_H  (IMG_H),
        .IMG_W  (IMG_W),
        .DR     (gi - P),
        .DC     (gj - P)
      ) u_fetch (
        .i_frame (r_frame),
        .i_row   (r_row),
        .i_col   (r_col),
        .o_pix   (win_data[(gi*K+gj)*DATA_W +: DATA_W])
      );
    end
  end

endmodule

// File: tb/tb_conv_window_seq.sv
// Directed bench for conv_window_seq: default 8x8/K3/3-pass instance plus a 4x6/K5/1-pass instance.
module tb_conv_window_seq;

`ifdef CONV_WIN_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic         start2;
  logic         win_ready;
  logic [511:0] in_tensor;
  logic [191:0] in2;

  logic         win_valid, win_last, busy, done;
  logic [71:0]  win_data;
  logic [2:0]   row, col;
  logic [1:0]   pass_idx;

  logic         win_valid2, win_last2, busy2, done2;
  logic [199:0] win_data2;
  logic [1:0]   row2;
  logic [2:0]   col2;
  logic [0:0]   pass2;

  int errs   = 0;
  int checks = 0;

  conv_window_seq dut (
    .clk(clk), .reset(reset), .start(start), .in_tensor(in_tensor),
    .win_ready(win_ready), .win_valid(win_valid), .win_data(win_data),
    .row(row), .col(col), .pass_idx(pass_idx), .win_last(win_last),
    .busy(busy), .done(done)
  );

  conv_window_seq #(.DATA_W(8), .IMG_H(4), .IMG_W(6), .K(5), .N_PASS(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_tensor(in2),
    .win_ready(win_ready), .win_valid(win_valid2), .win_data(win_data2),
    .row(row2), .col(col2), .pass_idx(pass2), .win_last(win_last2),
    .busy(busy2), .done(done2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] w3(input logic [71:0] d, input int i, input int j);
    return d[(i*3+j)*8 +: 8];
  endfunction

  function automatic logic [7:0] w5(input logic [199:0] d, input int i, input int j);
    return d[(i*5+j)*8 +: 8];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame_a;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_tensor[(r*8+c)*8 +: 8] = 8'(8*r + c);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({win_valid, busy, done, win_last} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 0000", {win_valid, busy, done, win_last});
    end
    checks++;
    if ({row, col, pass_idx} !== 8'd0) begin
      errs++; $display("FAIL reset_cnt: got row=%0d col=%0d pass=%0d expected 0", row, col, pass_idx);
    end
    checks++;
    if (win_data !== 72'd0) begin
      errs++; $display("FAIL reset_data: got %h expected 0", win_data);
    end
    checks++;
    if ({win_valid2, busy2, done2, win_last2} !== 4'b0000) begin
      errs++; $display("FAIL reset_ctrl2: got %b expected 0000", {win_valid2, busy2, done2, win_last2});
    end
    reset = 1'b0;
  endtask

  task automatic test_frame;
    int n;
    int lastcnt;
    logic [7:0] e;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    lastcnt = 0;
    checks++;
    if ({win_valid, busy, row, col, pass_idx} !== {2'b11, 8'd0}) begin
      errs++; $display("FAIL first_win: got v=%b b=%b row=%0d col=%0d pass=%0d expected v=1 b=1 at 0,0,0",
                       win_valid, busy, row, col, pass_idx);
    end
    checks++;
    if ({w3(win_data,0,0), w3(win_data,1,1), w3(win_data,2,2)} !== {8'd0, 8'd0, 8'd9}) begin
      errs++; $display("FAIL first_data: got %0d %0d %0d expected 0 0 9",
                       w3(win_data,0,0), w3(win_data,1,1), w3(win_data,2,2));
    end
    e = ZP ? 8'd0 : 8'd1;
    checks++;
    if (w3(win_data,0,2) !== e) begin
      errs++; $display("FAIL first_pad: got %0d expected %0d", w3(win_data,0,2), e);
    end
    while (done !== 1'b1 && n < 400) begin
      if (win_valid && row == 3'd7 && col == 3'd7) begin
        e = ZP ? 8'd0 : 8'd63;
        checks++;
        if ({w3(win_data,2,2), w3(win_data,1,1), w3(win_data,0,0)} !== {e, 8'd63, 8'd54}) begin
          errs++; $display("FAIL corner_data: got %0d %0d %0d expected %0d 63 54",
                           w3(win_data,2,2), w3(win_data,1,1), w3(win_data,0,0), e);
        end
        checks++;
        if ({win_last, pass_idx} !== {1'b1, 2'(lastcnt)}) begin
          errs++; $display("FAIL corner_last: got last=%b pass=%0d expected last=1 pass=%0d",
                           win_last, pass_idx, lastcnt);
        end
        lastcnt++;
      end else if (win_last) begin
        checks++;
        errs++; $display("FAIL spurious_last: got 1 at row=%0d col=%0d expected 0", row, col);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 193) begin
      errs++; $display("FAIL frame_len: got %0d expected 193", n);
    end
    checks++;
    if (lastcnt != 3) begin
      errs++; $display("FAIL last_count: got %0d expected 3", lastcnt);
    end
    tick();
    checks++;
    if ({done, busy, win_valid} !== 3'b000) begin
      errs++; $display("FAIL after_done: got %b expected 000", {done, busy, win_valid});
    end
  endtask

  task automatic test_stall;
    int n;
    logic [71:0] d;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pass_idx == 2'd1 && row == 3'd3 && col == 3'd4) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      errs++; $display("FAIL stall_reach: got timeout expected pass1 row3 col4");
    end
    win_ready = 1'b0;
    d = win_data;
    checks++;
    if ({w3(d,0,0), w3(d,1,1), w3(d,2,2)} !== {8'd19, 8'd28, 8'd37}) begin
      errs++; $display("FAIL stall_data: got %0d %0d %0d expected 19 28 37",
                       w3(d,0,0), w3(d,1,1), w3(d,2,2));
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (win_data !== d || {win_valid, pass_idx, row, col} !== {1'b1, 2'd1, 3'd3, 3'd4}) begin
        errs++; $display("FAIL stall_hold%0d: got row=%0d col=%0d pass=%0d data=%h expected 3 4 1 %h",
                         k, row, col, pass_idx, win_data, d);
      end
    end
    win_ready = 1'b1;
    tick();
    checks++;
    if ({row, col} !== {3'd3, 3'd5}) begin
      errs++; $display("FAIL stall_resume: got row=%0d col=%0d expected 3 5", row, col);
    end
  endtask

  task automatic test_reset_midscan;
    int n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pass_idx == 2'd1 && row == 3'd2) && n < 400) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({win_valid, busy, done, win_last, row, col, pass_idx} !== 12'd0 || win_data !== 72'd0) begin
      errs++; $display("FAIL mid_reset: got v=%b b=%b d=%b l=%b row=%0d col=%0d pass=%0d data=%h expected all 0",
                       win_valid, busy, done, win_last, row, col, pass_idx, win_data);
    end
    n = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || busy) n++;
    end
    checks++;
    if (n != 0) begin
      errs++; $display("FAIL mid_nodone: got %0d active cycles expected 0", n);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({win_valid, row, col, pass_idx} !== 9'b1_000_000_00 || w3(win_data,2,2) !== 8'd9) begin
      errs++; $display("FAIL mid_restart: got v=%b row=%0d col=%0d pass=%0d d22=%0d expected 1 0 0 0 9",
                       win_valid, row, col, pass_idx, w3(win_data,2,2));
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_start_held;
    int n;
    int dcnt;
    start = 1'b1;
    tick();
    n = 1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_tensor[(r*8+c)*8 +: 8] = 8'(8*r + c + 100);
    tick();
    n++;
    checks++;
    if ({row, col} !== {3'd0, 3'd1} || w3(win_data,1,1) !== 8'd1) begin
      errs++; $display("FAIL held_capture: got row=%0d col=%0d d11=%0d expected 0 1 1",
                       row, col, w3(win_data,1,1));
    end
    dcnt = 0;
    while (n < 193) begin
      tick();
      n++;
      if (done) dcnt++;
    end
    checks++;
    if (done !== 1'b1 || dcnt != 1) begin
      errs++; $display("FAIL held_done: got done=%b count=%0d expected 1 1", done, dcnt);
    end
    tick();
    checks++;
    if ({busy, win_valid, done} !== 3'b000) begin
      errs++; $display("FAIL held_idle: got %b expected 000", {busy, win_valid, done});
    end
    tick();
    checks++;
    if ({win_valid, row, col, pass_idx} !== 9'b1_000_000_00 || w3(win_data,1,1) !== 8'd100) begin
      errs++; $display("FAIL held_next: got v=%b row=%0d col=%0d d11=%0d expected 1 0 0 100",
                       win_valid, row, col, w3(win_data,1,1));
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_frame_a();
  endtask

  task automatic test_small;
    int n;
    int wcnt;
    logic [7:0] e;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        in2[(r*6+c)*8 +: 8] = 8'(10*r + c + 1);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    n = 1;
    wcnt = 0;
    e = ZP ? 8'd0 : 8'd1;
    checks++;
    if ({win_valid2, row2, col2} !== 6'b1_00_000 || w5(win_data2,0,0) !== e) begin
      errs++; $display("FAIL small_first: got v=%b row=%0d col=%0d d00=%0d expected 1 0 0 %0d",
                       win_valid2, row2, col2, w5(win_data2,0,0), e);
    end
    checks++;
    if ({w5(win_data2,2,2), w5(win_data2,4,4)} !== {8'd1, 8'd23}) begin
      errs++; $display("FAIL small_data: got %0d %0d expected 1 23",
                       w5(win_data2,2,2), w5(win_data2,4,4));
    end
    while (done2 !== 1'b1 && n < 100) begin
      if (win_valid2 && win_ready) wcnt++;
      tick();
      n++;
    end
    checks++;
    if (n != 25 || wcnt != 24) begin
      errs++; $display("FAIL small_len: got cycles=%0d windows=%0d expected 25 24", n, wcnt);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    start2    = 1'b0;
    win_ready = 1'b1;
    in2       = '0;
    load_frame_a();
    test_reset();
    test_frame();
    test_stall();
    test_reset_midscan();
    test_start_held();
    test_small();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
